nms_thresh: RTL and testbench

Non-maximum suppression and double-threshold classifier for the Canny pipeline. Sits directly downstream of the 3-line gradient window buffer: consumes the 3x3 gradient-magnitude window plus the centre pixel's signed dx/dy and the delayed sync pair, and emits one 2-bit edge class per pixel to the hysteresis stage. Fixed 3-cycle pipeline; borders forced to non-edge.

---
 rtl/canny_pkg.sv | 29 ++
 rtl/nms_dir_quant.sv | 41 ++++
 rtl/nms_thresh.sv | 253 +++++++++++++++++++++++++
 tb/tb_nms_thresh.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge pipeline.
//   edge_t      : 2-bit edge class handed to the hysteresis stage
//   dir_t       : quantised gradient direction (0/45/90/135 degrees)
//   nms_state_t : frame tracking state of nms_thresh
//   TAN_LO/HI   : integer ratio 2/5 approximating tan(22.5deg), 5/2 for tan(67.5deg)
package canny_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE   = 2'd0,
        EDGE_WEAK   = 2'd1,
        EDGE_STRONG = 2'd2
    } edge_t;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } nms_state_t;

    localparam logic [2:0] TAN_LO = 3'd2;
    localparam logic [2:0] TAN_HI = 3'd5;

endpackage

// File: rtl/nms_dir_quant.sv
// Gradient direction quantiser (purely combinational).
//   ax, ay : absolute values of dx / dy (unsigned, GW bits, up to 2^(GW-1))
//   sx, sy : sign bits of dx / dy (1 = negative)
//   dir    : nearest of the four NMS directions
module nms_dir_quant
    import canny_pkg::*;
#(
    parameter int GW = 11
)(
    input  logic [GW-1:0] ax,
    input  logic [GW-1:0] ay,
    input  logic          sx,
    input  logic          sy,
    output dir_t          dir
);

    // Three extra bits hold 5 * 2^(GW-1) without wrapping.
    logic [GW+2:0] ax2_s;
    logic [GW+2:0] ax5_s;
    logic [GW+2:0] ay2_s;
    logic [GW+2:0] ay5_s;

    // Compare ay/ax against 2/5 and 5/2 using cross-multiplication
    always_comb begin
        ax2_s = {3'b000, ax} * {{GW{1'b0}}, TAN_LO};
        ax5_s = {3'b000, ax} * {{GW{1'b0}}, TAN_HI};
        ay2_s = {3'b000, ay} * {{GW{1'b0}}, TAN_LO};
        ay5_s = {3'b000, ay} * {{GW{1'b0}}, TAN_HI};
        // dx = dy = 0 satisfies the first test and lands on DIR_0.
        if (ay5_s <= ax2_s) begin
            dir = DIR_0;
        end else if (ay2_s >= ax5_s) begin
            dir = DIR_90;
        end else if (sx == sy) begin
            dir = DIR_135;
        end else begin
            dir = DIR_45;
        end
    end

endmodule

// File: rtl/nms_thresh.sv
// Non-maximum suppression and double-threshold classifier.
// Three register stages: (1) capture window, |dx|/|dy|, signs, syncs;
// (2) direction, neighbour pick, border flag; (3) compare/threshold outputs.
//   clk, rst_b       : pixel clock, synchronous active-high reset
//   vvalid, hvalid   : frame / pixel valid levels aligned with win
//   win              : 3x3 magnitudes, gRC at [(3R+C)*DW +: DW], g11 centre
//   dx, dy           : signed centre gradients (dy positive downward)
//   th_lo, th_hi     : weak / strong thresholds, captured at frame start
//   vvalid_o,hvalid_o: syncs delayed 3 cycles
//   edge_o           : 0 none, 1 weak, 2 strong
//   mag_o            : centre magnitude, 0 when suppressed or on the border
module nms_thresh
    import canny_pkg::*;
#(
    parameter int DW = 8,
    parameter int GW = 11,
    parameter int CW = 11
)(
    input  logic            clk,
    input  logic            rst_b,
    input  logic            vvalid,
    input  logic            hvalid,
    input  logic [9*DW-1:0] win,
    input  logic [GW-1:0]   dx,
    input  logic [GW-1:0]   dy,
    input  logic [DW-1:0]   th_lo,
    input  logic [DW-1:0]   th_hi,
    output logic            vvalid_o,
    output logic            hvalid_o,
    output logic [1:0]      edge_o,
    output logic [DW-1:0]   mag_o
);

    nms_state_t      state_r;
    nms_state_t      state_nx_s;
    logic            vvalid_d_r;
    logic            acc_d_r;
    logic            rise_s;
    logic            in_frame_s;
    logic            accept_s;
    logic            first_s;
    logic [CW-1:0]   col_r;
    logic [CW-1:0]   row_r;
    logic [DW-1:0]   th_lo_r;
    logic [DW-1:0]   th_hi_r;
    logic [GW-1:0]   ax_s;
    logic [GW-1:0]   ay_s;

    logic            s1_hv_r;
    logic            s1_vv_r;
    logic            s1_first_r;
    logic            s1_sx_r;
    logic            s1_sy_r;
    logic [9*DW-1:0] s1_win_r;
    logic [GW-1:0]   s1_ax_r;
    logic [GW-1:0]   s1_ay_r;

    dir_t            dir_s;
    logic [DW-1:0]   n1_s;
    logic [DW-1:0]   n2_s;
    logic            border_s;
    logic            s2_hv_r;
    logic            s2_vv_r;
    logic            s2_border_r;
    logic [DW-1:0]   s2_c_r;
    logic [DW-1:0]   s2_n1_r;
    logic [DW-1:0]   s2_n2_r;

    logic            keep_s;
    edge_t           edge_nx_s;
    logic [DW-1:0]   mag_nx_s;
    logic            vvalid_r;
    logic            hvalid_r;
    edge_t           edge_r;
    logic [DW-1:0]   mag_r;

    // Frame entry detection and pixel acceptance; the rising-edge cycle itself is already in frame
    always_comb begin
        rise_s     = vvalid & ~vvalid_d_r;
        in_frame_s = vvalid & ((state_r == ACTIVE) | rise_s);
        accept_s   = in_frame_s & hvalid;
        first_s    = rise_s | (row_r == {CW{1'b0}}) | (col_r == {CW{1'b0}});
    end

    // Frame tracking next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            WAIT_FRAME: begin
                if (rise_s) state_nx_s = ACTIVE;
                else        state_nx_s = WAIT_FRAME;
            end
            ACTIVE: begin
                if (!vvalid) state_nx_s = WAIT_FRAME;
                else         state_nx_s = ACTIVE;
            end
            default: state_nx_s = WAIT_FRAME;
        endcase
    end

    // State register, sync history and per-frame threshold shadows
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_r    <= WAIT_FRAME;
            // Keep following vvalid during reset so a frame already in progress
            // is not mistaken for a new one; resume only on a genuine rise.
            vvalid_d_r <= vvalid;
            acc_d_r    <= 1'b0;
            th_lo_r    <= {DW{1'b0}};
            th_hi_r    <= {DW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            vvalid_d_r <= vvalid;
            acc_d_r    <= accept_s;
            if (rise_s) begin
                th_lo_r <= th_lo;
                th_hi_r <= th_hi;
            end
        end
    end

    // Row/column position of the pixel being accepted this cycle
    always_ff @(posedge clk) begin
        if (rst_b) begin
            col_r <= {CW{1'b0}};
            row_r <= {CW{1'b0}};
        end else if (rise_s) begin
            row_r <= {CW{1'b0}};
            col_r <= accept_s ? {{(CW-1){1'b0}}, 1'b1} : {CW{1'b0}};
        end else if (accept_s) begin
            col_r <= col_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (acc_d_r) begin
            col_r <= {CW{1'b0}};
            row_r <= row_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Absolute gradients; the most negative value maps onto 2^(GW-1) in GW unsigned bits
    always_comb begin
        if (dx[GW-1]) ax_s = ~dx + {{(GW-1){1'b0}}, 1'b1};
        else          ax_s = dx;
        if (dy[GW-1]) ay_s = ~dy + {{(GW-1){1'b0}}, 1'b1};
        else          ay_s = dy;
    end

    // Stage 1 capture
    always_ff @(posedge clk) begin
        if (rst_b) begin
            s1_hv_r    <= 1'b0;
            s1_vv_r    <= 1'b0;
            s1_first_r <= 1'b0;
            s1_sx_r    <= 1'b0;
            s1_sy_r    <= 1'b0;
            s1_win_r   <= {(9*DW){1'b0}};
            s1_ax_r    <= {GW{1'b0}};
            s1_ay_r    <= {GW{1'b0}};
        end else begin
            s1_hv_r    <= accept_s;
            s1_vv_r    <= in_frame_s;
            s1_first_r <= first_s;
            s1_sx_r    <= dx[GW-1];
            s1_sy_r    <= dy[GW-1];
            s1_win_r   <= win;
            s1_ax_r    <= ax_s;
            s1_ay_r    <= ay_s;
        end
    end

    nms_dir_quant #(.GW(GW)) u_dir (
        .ax  (s1_ax_r),
        .ay  (s1_ay_r),
        .sx  (s1_sx_r),
        .sy  (s1_sy_r),
        .dir (dir_s)
    );

    // Neighbour pair along the gradient (lower window index first) and border flag
    always_comb begin
        n1_s = s1_win_r[3*DW +: DW];
        n2_s = s1_win_r[5*DW +: DW];
        case (dir_s)
            DIR_0:   begin n1_s = s1_win_r[3*DW +: DW]; n2_s = s1_win_r[5*DW +: DW]; end
            DIR_45:  begin n1_s = s1_win_r[2*DW +: DW]; n2_s = s1_win_r[6*DW +: DW]; end
            DIR_90:  begin n1_s = s1_win_r[1*DW +: DW]; n2_s = s1_win_r[7*DW +: DW]; end
            DIR_135: begin n1_s = s1_win_r[0*DW +: DW]; n2_s = s1_win_r[8*DW +: DW]; end
            default: begin n1_s = s1_win_r[3*DW +: DW]; n2_s = s1_win_r[5*DW +: DW]; end
        endcase
        // The stage-1 pixel ends its line (or the frame) exactly when no pixel
        // is accepted right behind it: that covers last column and last row.
        border_s = s1_first_r | ~accept_s;
    end

    // Stage 2 capture
    always_ff @(posedge clk) begin
        if (rst_b) begin
            s2_hv_r     <= 1'b0;
            s2_vv_r     <= 1'b0;
            s2_border_r <= 1'b0;
            s2_c_r      <= {DW{1'b0}};
            s2_n1_r     <= {DW{1'b0}};
            s2_n2_r     <= {DW{1'b0}};
        end else begin
            s2_hv_r     <= s1_hv_r;
            s2_vv_r     <= s1_vv_r;
            s2_border_r <= border_s;
            s2_c_r      <= s1_win_r[4*DW +: DW];
            s2_n1_r     <= n1_s;
            s2_n2_r     <= n2_s;
        end
    end

    // Suppression (ties with the first neighbour survive) and double threshold
    always_comb begin
        keep_s    = 1'b0;
        edge_nx_s = EDGE_NONE;
        mag_nx_s  = {DW{1'b0}};
        if (s2_hv_r && !s2_border_r && (s2_c_r >= s2_n1_r) && (s2_c_r > s2_n2_r)) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
        if (keep_s) begin
            mag_nx_s = s2_c_r;
            if (s2_c_r >= th_hi_r)      edge_nx_s = EDGE_STRONG;
            else if (s2_c_r >= th_lo_r) edge_nx_s = EDGE_WEAK;
            else                        edge_nx_s = EDGE_NONE;
        end else begin
            mag_nx_s  = {DW{1'b0}};
            edge_nx_s = EDGE_NONE;
        end
    end

    // Stage 3 output registers
    always_ff @(posedge clk) begin
        if (rst_b) begin
            vvalid_r <= 1'b0;
            hvalid_r <= 1'b0;
            edge_r   <= EDGE_NONE;
            mag_r    <= {DW{1'b0}};
        end else begin
            vvalid_r <= s2_vv_r;
            hvalid_r <= s2_hv_r;
            edge_r   <= edge_nx_s;
            mag_r    <= mag_nx_s;
        end
    end

    assign vvalid_o = vvalid_r;
    assign hvalid_o = hvalid_r;
    assign edge_o   = edge_r;
    assign mag_o    = mag_r;

endmodule

// File: tb/tb_nms_thresh.sv
// Scoreboard bench for nms_thresh: the driver pushes hand-computed
// expectations per accepted pixel; the monitor pops on hvalid_o.
module tb_nms_thresh;

    localparam int DW = 8;
    localparam int GW = 11;
    localparam int CW = 11;
    localparam int W  = 8;
    localparam int H  = 4;

    logic            clk = 1'b0;
    logic            rst_b = 1'b1;
    logic            vvalid = 1'b0;
    logic            hvalid = 1'b0;
    logic [9*DW-1:0] win = {(9*DW){1'b0}};
    logic [GW-1:0]   dx = {GW{1'b0}};
    logic [GW-1:0]   dy = {GW{1'b0}};
    logic [DW-1:0]   th_lo = {DW{1'b0}};
    logic [DW-1:0]   th_hi = {DW{1'b0}};
    logic            vvalid_o;
    logic            hvalid_o;
    logic [1:0]      edge_o;
    logic [DW-1:0]   mag_o;

    typedef struct {
        int            due;
        logic [1:0]    e;
        logic [DW-1:0] m;
        int            id;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pix_id = 0;
    logic exp_vv_in = 1'b0;
    logic vp0 = 1'b0;
    logic vp1 = 1'b0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    // special-pixel and mid-frame threshold configuration for run_frame
    int            sp_r = -1;
    int            sp_c = -1;
    logic [9*DW-1:0] sp_w;
    logic [GW-1:0] sp_dx;
    logic [GW-1:0] sp_dy;
    logic [1:0]    sp_e;
    logic [DW-1:0] sp_m;
    int            th_row = -1;
    logic [DW-1:0] new_lo;
    logic [DW-1:0] new_hi;

    nms_thresh #(.DW(DW), .GW(GW), .CW(CW)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .vvalid   (vvalid),
        .hvalid   (hvalid),
        .win      (win),
        .dx       (dx),
        .dy       (dy),
        .th_lo    (th_lo),
        .th_hi    (th_hi),
        .vvalid_o (vvalid_o),
        .hvalid_o (hvalid_o),
        .edge_o   (edge_o),
        .mag_o    (mag_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9*DW-1:0] mkwin(input logic [DW-1:0] g00, g01, g02,
                                              g10, g11, g12, g20, g21, g22);
        return {g22, g21, g20, g12, g11, g10, g02, g01, g00};
    endfunction

    // Monitor: sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (rst_b) begin
            vp0 = 1'b0;
            vp1 = 1'b0;
            q.delete();
            checks++;
            if (edge_o !== 2'd0 || mag_o !== 8'd0) begin
                errors++;
                $display("FAIL reset_out cyc=%0d edge=%0d mag=%0d want 0/0", cyc, edge_o, mag_o);
            end
        end
        checks++;
        if (vvalid_o !== vp1) begin
            errors++;
            $display("FAIL vvalid_o cyc=%0d got=%b want=%b", cyc, vvalid_o, vp1);
        end
        vp1 = vp0;
        vp0 = exp_vv_in;
        if (hvalid_o === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel cyc=%0d edge=%0d mag=%0d want no output", cyc, edge_o, mag_o);
            end else begin
                ex = q.pop_front();
                if (ex.due != cyc || edge_o !== ex.e || mag_o !== ex.m) begin
                    errors++;
                    $display("FAIL pixel id=%0d cyc=%0d due=%0d edge=%0d want %0d mag=%0d want %0d",
                             ex.id, cyc, ex.due, edge_o, ex.e, mag_o, ex.m);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            checks++;
            errors++;
            ex = q.pop_front();
            $display("FAIL missing_pixel id=%0d cyc=%0d due=%0d hvalid_o=%b want 1", ex.id, cyc, ex.due, hvalid_o);
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain pending=%0d want 0", q.size());
            end
        end
    end

    task automatic drive(input logic v, input logic h, input logic [9*DW-1:0] w,
                         input logic [GW-1:0] x, input logic [GW-1:0] y, input logic r,
                         input logic ok, input logic push, input logic [1:0] e,
                         input logic [DW-1:0] m);
        @(negedge clk);
        rst_b     = r;
        vvalid    = v;
        hvalid    = h;
        win       = w;
        dx        = x;
        dy        = y;
        exp_vv_in = ok;
        if (push) q.push_back('{cyc + 3, e, m, pix_id});
        pix_id++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, {(9*DW){1'b0}}, {GW{1'b0}}, {GW{1'b0}}, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    // bg=1: interior pixels are an isolated 200 peak (strong unless border),
    // bg=0: flat 100 field (always suppressed). Last row always flat.
    task automatic run_frame(input int bg, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                             input int rst_row);
        logic            dropped;
        logic            border;
        logic            rst_now;
        logic [9*DW-1:0] w;
        logic [GW-1:0]   x;
        logic [GW-1:0]   y;
        logic [1:0]      e;
        logic [DW-1:0]   m;
        dropped = 1'b0;
        th_lo = lo;
        th_hi = hi;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == th_row && c == 0) begin
                    th_lo = new_lo;
                    th_hi = new_hi;
                end
                border = (r == 0) || (c == 0) || (c == W - 1) || (r == H - 1);
                x = {GW{1'b0}};
                y = {GW{1'b0}};
                if (r == sp_r && c == sp_c) begin
                    w = sp_w; x = sp_dx; y = sp_dy; e = sp_e; m = sp_m;
                end else if (bg == 1 && r != H - 1) begin
                    w = mkwin(8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0);
                    e = border ? 2'd0 : 2'd2;
                    m = border ? 8'd0 : 8'd200;
                end else begin
                    w = mkwin(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
                    e = 2'd0;
                    m = 8'd0;
                end
                rst_now = (r == rst_row) && (c == 3);
                if (rst_now) dropped = 1'b1;
                drive(1'b1, 1'b1, w, x, y, rst_now, !dropped, !dropped, e, m);
            end
            if (r != H - 1) begin
                for (int g = 0; g < 3; g++)
                    drive(1'b1, 1'b0, {(9*DW){1'b0}}, {GW{1'b0}}, {GW{1'b0}}, 1'b0, !dropped, 1'b0, 2'd0, 8'd0);
            end
        end
        idle(6);
        sp_r = -1;
        sp_c = -1;
        th_row = -1;
    endtask

    initial begin
        rst_b = 1'b1;
        repeat (25) @(negedge clk);
        idle(3);

        // flat field: ties pass the first compare but fail the strict one
        run_frame(0, 8'd20, 8'd80, -1);

        // DIR_0 peak over 50/50 neighbours, non-neighbours high
        sp_r = 1; sp_c = 3;
        sp_w = mkwin(8'd255, 8'd255, 8'd255, 8'd50, 8'd200, 8'd50, 8'd255, 8'd255, 8'd255);
        sp_dx = 11'd40; sp_dy = 11'd0; sp_e = 2'd2; sp_m = 8'd200;
        run_frame(1, 8'd60, 8'd150, -1);

        // DIR_135 suppressed by g00=250
        sp_r = 1; sp_c = 3;
        sp_w = mkwin(8'd250, 8'd0, 8'd0, 8'd0, 8'd120, 8'd0, 8'd0, 8'd0, 8'd0);
        sp_dx = 11'd10; sp_dy = 11'd10; sp_e = 2'd0; sp_m = 8'd0;
        run_frame(1, 8'd60, 8'd150, -1);

        // DIR_45 with g02=g20=0 kept as weak
        sp_r = 2; sp_c = 4;
        sp_w = mkwin(8'd250, 8'd250, 8'd0, 8'd250, 8'd120, 8'd250, 8'd0, 8'd250, 8'd250);
        sp_dx = 11'd10; sp_dy = 11'h7F6; sp_e = 2'd1; sp_m = 8'd120;
        run_frame(1, 8'd60, 8'd150, -1);

        // DIR_90 at dy = -1024, thresholds changed mid-frame must not apply yet
        sp_r = 2; sp_c = 3;
        sp_w = mkwin(8'd250, 8'd0, 8'd250, 8'd250, 8'd90, 8'd250, 8'd250, 8'd0, 8'd250);
        sp_dx = 11'd0; sp_dy = 11'h400; sp_e = 2'd1; sp_m = 8'd90;
        th_row = 1; new_lo = 8'd10; new_hi = 8'd20;
        run_frame(1, 8'd60, 8'd150, -1);

        // next frame picks up 10/20: same pixel becomes strong
        sp_r = 2; sp_c = 3;
        sp_w = mkwin(8'd250, 8'd0, 8'd250, 8'd250, 8'd90, 8'd250, 8'd250, 8'd0, 8'd250);
        sp_dx = 11'd0; sp_dy = 11'h400; sp_e = 2'd2; sp_m = 8'd90;
        run_frame(1, 8'd10, 8'd20, -1);

        // reset pulse in row 2: rest of frame dropped, next frame restarts counters
        run_frame(1, 8'd60, 8'd150, 2);
        run_frame(1, 8'd60, 8'd150, -1);

        idle(10);
        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
